// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end: column scan, 2-flop row synchronizer, round classification
// and press/release debounce producing the button/bstate pair for the lock's validity checker.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIV     = 16'd1000,
  parameter logic [7:0]  DEBOUNCE_CNT = 8'd4,
  parameter logic [63:0] KEYMAP       = 64'hFEDCBA9876543210
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] button,
  output logic       bstate,
  output logic       ghost
);

  // state    | meaning
  // IDLE     | no key accepted, waiting for a single-key round
  // PRESS_DB | candidate key seen, counting consecutive identical rounds
  // PRESSED  | key accepted, bstate high, other keys ignored
  // REL_DB   | key accepted, counting consecutive empty rounds
  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

  state_t     state, state_n;
  logic [3:0] sync1, rows_s;
  logic [15:0] slot;
  logic [1:0] col;
  logic [1:0] acc_cnt;
  logic [3:0] acc_p;
  logic [2:0] cnt_now, total;
  logic [1:0] row_now;
  logic       slot_end, round_end, r_none, r_key, r_multi;
  logic [3:0] key_p;
  logic [7:0] dc, dc_n, dc_inc;
  logic [3:0] cand, cand_n, button_n;
  logic       bstate_n;

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      sync1  <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      sync1  <= rows;
      rows_s <= sync1;
    end
  end

  assign slot_end  = (slot == SCAN_DIV - 16'd1);
  assign round_end = slot_end && (col == 2'd3);
  assign cols      = ~(4'b0001 << col);

  always_comb begin
    cnt_now = 3'd0;
    row_now = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rows_s[i]) begin
        cnt_now = cnt_now + 3'd1;
        row_now = i[1:0];
      end
    end
  end

  // The accumulated count saturates at 2; that is enough to tell NONE, KEY and MULTI apart.
  assign total   = {1'b0, acc_cnt} + cnt_now;
  assign r_none  = (total == 3'd0);
  assign r_key   = (total == 3'd1);
  assign r_multi = (total >= 3'd2);
  assign key_p   = (acc_cnt == 2'd0) ? {row_now, col} : acc_p;
  assign dc_inc  = (dc == 8'hFF) ? dc : dc + 8'd1;

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      slot    <= 16'd0;
      col     <= 2'd0;
      acc_cnt <= 2'd0;
      acc_p   <= 4'd0;
      ghost   <= 1'b0;
    end else begin
      ghost <= round_end && r_multi;
      if (slot_end) begin
        slot <= 16'd0;
        col  <= col + 2'd1;
        if (round_end) begin
          acc_cnt <= 2'd0;
          acc_p   <= 4'd0;
        end else begin
          acc_cnt <= r_multi ? 2'd2 : total[1:0];
          acc_p   <= key_p;
        end
      end else begin
        slot <= slot + 16'd1;
      end
    end
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dc     <= 8'd0;
      cand   <= 4'd0;
      button <= 4'h0;
      bstate <= 1'b0;
    end else begin
      state  <= state_n;
      dc     <= dc_n;
      cand   <= cand_n;
      button <= button_n;
      bstate <= bstate_n;
    end
  end

  // The threshold is tested on the updated count, so DEBOUNCE_CNT=1 accepts or releases
  // on the very round that starts the streak.
  always_comb begin
    state_n  = state;
    dc_n     = dc;
    cand_n   = cand;
    button_n = button;
    bstate_n = bstate;
    if (round_end) begin
      case (state)
        IDLE, PRESS_DB: begin
          if (r_key) begin
            if (state == PRESS_DB && key_p == cand) begin
              dc_n = dc_inc;
            end else begin
              cand_n = key_p;
              dc_n   = 8'd1;
            end
            if (dc_n >= DEBOUNCE_CNT) begin
              button_n = KEYMAP[{cand_n, 2'b00} +: 4];
              bstate_n = 1'b1;
              state_n  = PRESSED;
            end else begin
              state_n = PRESS_DB;
            end
          end else begin
            state_n = IDLE;
          end
        end
        PRESSED, REL_DB: begin
          if (r_none) begin
            dc_n = (state == REL_DB) ? dc_inc : 8'd1;
            if (dc_n >= DEBOUNCE_CNT) begin
              bstate_n = 1'b0;
              state_n  = IDLE;
            end else begin
              state_n = REL_DB;
            end
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model drives rows from cols, and a
// round-level model (sliding window over round outcomes) predicts bstate/button/ghost.
module tb_keypad_scanner;
  localparam logic [15:0] SD  = 16'd4;
  localparam logic [7:0]  DB  = 8'd3;
  localparam int          DEB = 3;
  localparam int          RND = 16;
  localparam logic [63:0] KM0 = 64'hFEDCBA9876543210;
  localparam logic [63:0] KM1 = 64'h0123456789ABCDEF;

  logic        hwclk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys0 = 16'h0, keys1 = 16'h0;
  logic [3:0]  rows0, rows1, cols0, cols1, button0, button1;
  logic        bstate0, bstate1, ghost0, ghost1;
  int          n_cmp = 0, n_bad = 0;

  always #5 hwclk = ~hwclk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .KEYMAP(KM0)) dut (
    .hwclk(hwclk), .reset(reset), .rows(rows0), .cols(cols0),
    .button(button0), .bstate(bstate0), .ghost(ghost0));

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .KEYMAP(KM1)) dut_r (
    .hwclk(hwclk), .reset(reset), .rows(rows1), .cols(cols1),
    .button(button1), .bstate(bstate1), .ghost(ghost1));

  // A row reads low when any held key on it sits in a currently driven (low) column.
  function automatic logic [3:0] matrix(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] m;
    for (int r = 0; r < 4; r++) m[r] = ~|(k[r*4 +: 4] & ~c);
    return m;
  endfunction

  assign rows0 = matrix(keys0, cols0);
  assign rows1 = matrix(keys1, cols1);

  int   rise0 = 0, rise1 = 0, gh0 = 0, colv = 0;
  logic pb0 = 1'b0, pb1 = 1'b0;
  always @(negedge hwclk) begin
    pb0 <= bstate0;
    pb1 <= bstate1;
    if (bstate0 && !pb0) rise0 <= rise0 + 1;
    if (bstate1 && !pb1) rise1 <= rise1 + 1;
    if (ghost0) gh0 <= gh0 + 1;
    if ($countones(~cols0) != 1 || $countones(~cols1) != 1) colv <= colv + 1;
  end

  // Round-level reference: -1 = no key, -2 = several keys, else the position.
  int         hist [2][8];
  int         nh [2];
  logic       mheld [2];
  logic [3:0] mcode [2];
  logic       mghost [2];

  function automatic int classify(input logic [15:0] k);
    if ($countones(k) == 0) return -1;
    if ($countones(k) > 1) return -2;
    for (int p = 0; p < 16; p++) if (k[p]) return p;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      nh[d] = 0; mheld[d] = 1'b0; mcode[d] = 4'h0; mghost[d] = 1'b0;
    end
  endtask

  // Accept when the last DEB rounds were the same single key; release when the last DEB were empty.
  task automatic model_step(input int d, input logic [15:0] k, input logic [63:0] km);
    int r;
    bit same;
    logic [63:0] kmv;
    kmv = km;
    r = classify(k);
    for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = r;
    if (nh[d] < 8) nh[d]++;
    mghost[d] = (r == -2);
    same = (nh[d] >= DEB);
    for (int i = 0; i < DEB; i++) if (hist[d][i] != r) same = 0;
    if (mheld[d]) begin
      if (same && r == -1) mheld[d] = 1'b0;
    end else if (same && r >= 0) begin
      mheld[d] = 1'b1;
      mcode[d] = kmv[r*4 +: 4];
    end
  endtask

  task automatic run_round(input logic [15:0] k0, input logic [15:0] k1);
    keys0 = k0;
    keys1 = k1;
    repeat (RND) @(posedge hwclk);
    #1;
    model_step(0, k0, KM0);
    model_step(1, k1, KM1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge hwclk);
    @(negedge hwclk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (cols0 !== 4'b1110) begin n_bad++; $display("FAIL reset_cols got %b want 1110", cols0); end
    n_cmp++; if (button0 !== 4'h0) begin n_bad++; $display("FAIL reset_button got %h want 0", button0); end
    n_cmp++; if (bstate0 !== 1'b0) begin n_bad++; $display("FAIL reset_bstate got %b want 0", bstate0); end
    n_cmp++; if (ghost0 !== 1'b0) begin n_bad++; $display("FAIL reset_ghost got %b want 0", ghost0); end
    n_cmp++; if (cols1 !== 4'b1110) begin n_bad++; $display("FAIL reset_cols_r got %b want 1110", cols1); end
    @(negedge hwclk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single_press();
    int rb;
    do_reset();
    rb = rise0;
    for (int i = 1; i <= 10; i++) begin
      run_round(16'h0040, 16'h0);
      n_cmp++; if (bstate0 !== mheld[0]) begin n_bad++; $display("FAIL press_bstate r%0d got %b want %b", i, bstate0, mheld[0]); end
      n_cmp++; if (button0 !== mcode[0]) begin n_bad++; $display("FAIL press_button r%0d got %h want %h", i, button0, mcode[0]); end
      if (i == 2) begin
        n_cmp++; if (bstate0 !== 1'b0) begin n_bad++; $display("FAIL press_early got %b want 0", bstate0); end
      end
      if (i == 3) begin
        n_cmp++; if (bstate0 !== 1'b1 || button0 !== 4'h6) begin n_bad++; $display("FAIL press_accept got %b/%h want 1/6", bstate0, button0); end
      end
    end
    for (int i = 1; i <= 4; i++) begin
      run_round(16'h0, 16'h0);
      n_cmp++; if (bstate0 !== mheld[0] || button0 !== mcode[0]) begin n_bad++; $display("FAIL release r%0d got %b/%h want %b/%h", i, bstate0, button0, mheld[0], mcode[0]); end
      if (i == 2) begin
        n_cmp++; if (bstate0 !== 1'b1) begin n_bad++; $display("FAIL release_early got %b want 1", bstate0); end
      end
      if (i == 3) begin
        n_cmp++; if (bstate0 !== 1'b0 || button0 !== 4'h6) begin n_bad++; $display("FAIL release_done got %b/%h want 0/6", bstate0, button0); end
      end
    end
    n_cmp++; if (rise0 - rb !== 1) begin n_bad++; $display("FAIL press_rises got %0d want 1", rise0 - rb); end
  endtask

  task automatic test_short_press();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      run_round((i <= 2) ? 16'h0040 : 16'h0, 16'h0);
      n_cmp++; if (bstate0 !== 1'b0 || button0 !== 4'h0) begin n_bad++; $display("FAIL short_press r%0d got %b/%h want 0/0", i, bstate0, button0); end
      n_cmp++; if (bstate0 !== mheld[0]) begin n_bad++; $display("FAIL short_model r%0d got %b want %b", i, bstate0, mheld[0]); end
    end
  endtask

  task automatic test_ghost();
    int gb;
    do_reset();
    gb = gh0;
    for (int i = 1; i <= 5; i++) begin
      run_round(16'h0042, 16'h0);
      n_cmp++; if (ghost0 !== 1'b1 || ghost0 !== mghost[0]) begin n_bad++; $display("FAIL ghost_pulse r%0d got %b want 1", i, ghost0); end
      n_cmp++; if (bstate0 !== 1'b0) begin n_bad++; $display("FAIL ghost_bstate r%0d got %b want 0", i, bstate0); end
    end
    for (int i = 1; i <= 4; i++) begin
      run_round(16'h0040, 16'h0);
      n_cmp++; if (bstate0 !== mheld[0] || button0 !== mcode[0] || ghost0 !== 1'b0) begin n_bad++; $display("FAIL ghost_recover r%0d got %b/%h/%b want %b/%h/0", i, bstate0, button0, ghost0, mheld[0], mcode[0]); end
      if (i == 3) begin
        n_cmp++; if (bstate0 !== 1'b1 || button0 !== 4'h6) begin n_bad++; $display("FAIL ghost_accept got %b/%h want 1/6", bstate0, button0); end
      end
    end
    n_cmp++; if (gh0 - gb !== 5) begin n_bad++; $display("FAIL ghost_count got %0d want 5", gh0 - gb); end
  endtask

  task automatic test_keymap();
    int rb;
    do_reset();
    rb = rise1;
    for (int i = 1; i <= 8; i++) begin
      run_round(16'h0, (i <= 4) ? 16'h0001 : 16'h0021);
      n_cmp++; if (bstate1 !== mheld[1] || button1 !== mcode[1]) begin n_bad++; $display("FAIL keymap r%0d got %b/%h want %b/%h", i, bstate1, button1, mheld[1], mcode[1]); end
      if (i >= 3) begin
        n_cmp++; if (bstate1 !== 1'b1 || button1 !== 4'hF) begin n_bad++; $display("FAIL keymap_code r%0d got %b/%h want 1/f", i, bstate1, button1); end
      end
    end
    n_cmp++; if (rise1 - rb !== 1) begin n_bad++; $display("FAIL keymap_rises got %0d want 1", rise1 - rb); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 4; i++) run_round(16'h0040, 16'h0);
    n_cmp++; if (bstate0 !== 1'b1 || button0 !== 4'h6) begin n_bad++; $display("FAIL midrst_pre got %b/%h want 1/6", bstate0, button0); end
    repeat (6) @(posedge hwclk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (bstate0 !== 1'b0 || button0 !== 4'h0) begin n_bad++; $display("FAIL midrst_async got %b/%h want 0/0", bstate0, button0); end
    n_cmp++; if (cols0 !== 4'b1110) begin n_bad++; $display("FAIL midrst_cols got %b want 1110", cols0); end
    @(posedge hwclk);
    @(negedge hwclk);
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 4; i++) begin
      run_round(16'h0040, 16'h0);
      n_cmp++; if (bstate0 !== mheld[0] || button0 !== mcode[0]) begin n_bad++; $display("FAIL midrst_redo r%0d got %b/%h want %b/%h", i, bstate0, button0, mheld[0], mcode[0]); end
      if (i == 2) begin
        n_cmp++; if (bstate0 !== 1'b0) begin n_bad++; $display("FAIL midrst_early got %b want 0", bstate0); end
      end
    end
  endtask

  task automatic test_bounce();
    int rb, gb;
    do_reset();
    rb = rise0;
    gb = gh0;
    keys0 = 16'h0040;
    for (int c = 0; c < 2 * RND; c++) begin
      if (c % 5 == 4) keys0 = keys0 ^ 16'h0040;
      @(posedge hwclk);
      #1;
    end
    keys0 = 16'h0040;
    repeat (5 * RND) @(posedge hwclk);
    #1;
    n_cmp++; if (bstate0 !== 1'b1 || button0 !== 4'h6) begin n_bad++; $display("FAIL bounce_final got %b/%h want 1/6", bstate0, button0); end
    n_cmp++; if (rise0 - rb !== 1) begin n_bad++; $display("FAIL bounce_rises got %0d want 1", rise0 - rb); end
    n_cmp++; if (gh0 - gb !== 0) begin n_bad++; $display("FAIL bounce_ghost got %0d want 0", gh0 - gb); end
  endtask

  function automatic logic [15:0] rand_keys();
    int sel, a;
    sel = int'($urandom_range(0, 9));
    a = 3 * int'($urandom_range(0, 5));
    if (sel < 4) return 16'h0;
    if (sel < 8) return 16'h1 << a;
    return (16'h1 << a) | (16'h1 << ((a + int'($urandom_range(1, 15))) % 16));
  endfunction

  task automatic test_random();
    int gb, gexp, hold;
    logic [15:0] k0, k1;
    do_reset();
    gb = gh0;
    gexp = 0;
    hold = 0;
    k0 = 16'h0;
    k1 = 16'h0;
    for (int i = 0; i < 80; i++) begin
      if (hold == 0) begin
        k0 = rand_keys();
        k1 = rand_keys();
        hold = int'($urandom_range(1, 5));
      end
      hold--;
      run_round(k0, k1);
      if (mghost[0]) gexp++;
      n_cmp++; if (bstate0 !== mheld[0] || button0 !== mcode[0] || ghost0 !== mghost[0]) begin n_bad++; $display("FAIL rand r%0d keys %h got %b/%h/%b want %b/%h/%b", i, k0, bstate0, button0, ghost0, mheld[0], mcode[0], mghost[0]); end
      n_cmp++; if (bstate1 !== mheld[1] || button1 !== mcode[1] || ghost1 !== mghost[1]) begin n_bad++; $display("FAIL rand_r r%0d keys %h got %b/%h/%b want %b/%h/%b", i, k1, bstate1, button1, ghost1, mheld[1], mcode[1], mghost[1]); end
    end
    @(negedge hwclk);
    n_cmp++; if (gh0 - gb !== gexp) begin n_bad++; $display("FAIL rand_ghost_count got %0d want %0d", gh0 - gb, gexp); end
  endtask

  task automatic test_cols();
    n_cmp++; if (colv !== 0) begin n_bad++; $display("FAIL cols_onehot violations %0d want 0", colv); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_short_press();
    test_ghost();
    test_keymap();
    test_reset_mid();
    test_bounce();
    test_random();
    test_cols();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the digital lock: drives a 4x4 keypad column-by-column, synchronizes and debounces the row returns, and presents one accepted key as a 4-bit code plus a level strobe. It is the producer side of the `button`/`bstate` interface consumed by the lock's validity checker, which samples `button` on the falling edge of `bstate`. It guarantees one clean `bstate` pulse per physical keypress and a `button` value that is stable across that falling edge.

## Interface
- `SCAN_DIV`, 16'd1000: clock cycles per column slot (range 2..65535).
- `DEBOUNCE_CNT`, 8'd4: consecutive identical scan rounds needed to accept a press or a release (range 1..255).
- `KEYMAP`, 64'hFEDCBA9876543210: nibble `p` (bits `4p+3:4p`) is the code emitted for matrix position `p = row*4 + col`.
- `hwclk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `rows` input 4: keypad row returns, active-low, asynchronous to `hwclk`.
- `cols` output 4: column drive, active-low, exactly one bit low at all times.
- `button` output 4: code of the last accepted key; changes only when a press is accepted.
- `bstate` output 1: high while the accepted key is held (debounced).
- `ghost` output 1: one-cycle pulse when a scan round sees two or more keys.

## Operation
- `rows` passes through a 2-flop synchronizer before any use.
- Column counter `c` (0..3) drives `cols = ~(1<<c)`. A slot counter runs 0..SCAN_DIV-1; the synchronized rows are sampled on the last cycle of each slot, then `c` increments and wraps 3->0. One round = 4*SCAN_DIV cycles.
- At the end of a round (slot end with `c==3`), the round result is one of:
  - NONE: no low row bit in any column.
  - KEY(p): exactly one low bit over the whole round.
  - MULTI: two or more low bits. `ghost` pulses in the following cycle.
- A debounce counter `dc` (8 bits, saturating) counts consecutive qualifying rounds. FSM states:
  - IDLE: on KEY(p), latch candidate `p`, set `dc=1`, go to PRESS_DB. Stay in IDLE on NONE or MULTI.
  - PRESS_DB: KEY(same p) increments `dc`. KEY(other p) re-latches the candidate with `dc=1`. NONE or MULTI returns to IDLE. When `dc` reaches DEBOUNCE_CNT, set `button=KEYMAP[p]` and `bstate=1`, then go to PRESSED.
  - PRESSED: KEY(any) or MULTI stays here (no rollover; a second key is ignored). NONE sets `dc=1` and goes to REL_DB.
  - REL_DB: NONE increments `dc`. KEY or MULTI returns to PRESSED with `bstate` still 1. When `dc` reaches DEBOUNCE_CNT, `bstate=0` and go to IDLE; `button` is unchanged.
- With DEBOUNCE_CNT=1, acceptance happens on the same round-end as the first qualifying round, and the FSM passes through PRESS_DB/REL_DB for zero cycles.
- Reset values: `cols=4'b1110`, `button=4'h0`, `bstate=0`, `ghost=0`, FSM=IDLE, all counters 0, synchronizer flops all 1 (released).

## Timing
- Round-end evaluation and FSM update occur on the round's final slot edge. `bstate`/`button` register on that same edge, so they are visible 1 cycle after the final sample.
- Press latency: `bstate` rises at most (DEBOUNCE_CNT+1)*4*SCAN_DIV + 3 cycles after a stable press (2-cycle sync, partial first round).
- Release latency has the same bound. `button` is stable from its update until the next acceptance, so it is valid for at least DEBOUNCE_CNT rounds after `bstate` falls.
- `button` and the `bstate` rising edge change on the same clock edge; `button` never changes while `bstate=1`.
- Asserting `reset` mid-press immediately forces the outputs to their reset values. After release, scanning restarts at column 0 and a still-held key must re-debounce from IDLE.

## Test plan
- SCAN_DIV=4, DEBOUNCE_CNT=3, identity KEYMAP; hold position 6 (row1, col2) for 10 rounds -> `bstate` rises once, on the 3rd qualifying round-end, with `button=4'h6`. After release, `bstate` falls exactly 3 rounds later and `button` stays `4'h6`.
- Same setup; row line bounces (toggles every 5 cycles) for 2 rounds, then held stable -> exactly one `bstate` rising edge and `ghost` never pulses.
- Press held for only 2 rounds -> `bstate` stays 0 and `button` stays `4'h0`.
- Positions 1 and 6 pressed together for 5 rounds -> `ghost` pulses at each round-end and `bstate` stays 0. Release 1 while keeping 6 -> `bstate` rises after 3 rounds with `button=4'h6`.
- KEYMAP=64'h0123456789ABCDEF; press position 0 -> `button=4'hF`. While it is held, press position 5 -> no new `bstate` edge and `button` stays `4'hF`.
- Assert `reset` for 1 cycle while `bstate=1` with the key held -> `bstate=0`, `button=0`, `cols=4'b1110` asynchronously. `bstate` re-asserts after 3 rounds with the same code.
